// File: rtl/hack_clk_monitor.sv
// hack_clk_monitor: watches the divided Hack clock from the 100 MHz domain and
// reports a rising-edge strobe, the measured period, lock and sticky error status.
module hack_clk_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int EXP_PERIOD  = 3,
    parameter int EXP_HIGH    = 1,
    parameter int LOCK_COUNT  = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hack_clk,
    input  logic             err_clr,
    output logic             rise,
    output logic             locked,
    output logic             err,
    output logic [7:0]       period,
    output logic [CNT_W-1:0] edge_count
);
    localparam int                GOOD_W      = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [7:0]        EXP_LEN     = 8'(EXP_PERIOD);
    localparam logic [7:0]        EXP_HI      = 8'(EXP_HIGH);
    localparam logic [7:0]        TIMEOUT_LEN = 8'(2 * EXP_PERIOD);
    localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_COUNT);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    state_t            state;
    state_t            state_nx;
    logic              s;
    logic              prev;
    logic              edge_det;
    logic [7:0]        len;
    logic [7:0]        hi;
    logic [GOOD_W-1:0] good_cnt;
    logic [GOOD_W-1:0] good_nx;
    logic [GOOD_W-1:0] good_inc;
    logic              period_ok;
    logic              eval;
    logic              bad;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign s = hack_clk;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= hack_clk;
                    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end
            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign edge_det  = s & ~prev;
    assign period_ok = (len == EXP_LEN) && (hi == EXP_HI);
    assign good_inc  = good_cnt + GOOD_W'(1);

    // len/hi hold the period and high time of the period ending at the current edge
    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= 1'b0;
            len  <= '0;
            hi   <= '0;
        end else begin
            prev <= s;
            if (edge_det) begin
                len <= 8'd1;
                hi  <= 8'd1;
            end else begin
                if (len != '1) len <= len + 8'd1;
                if (s && (hi != '1)) hi <= hi + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SEARCH;
            good_cnt <= '0;
        end else begin
            state    <= state_nx;
            good_cnt <= good_nx;
        end
    end

    // An edge takes priority over a coinciding timeout, so that period is judged bad
    always_comb begin
        state_nx = state;
        good_nx  = good_cnt;
        eval     = 1'b0;
        bad      = 1'b0;
        case (state)
            SEARCH: begin
                if (edge_det) state_nx = TRACK;
            end
            TRACK, LOCKED: begin
                if (edge_det) begin
                    eval = 1'b1;
                    if (period_ok) begin
                        if (state == TRACK) begin
                            good_nx = good_inc;
                            if (good_inc == GOOD_TARGET) state_nx = LOCKED;
                        end
                    end else begin
                        bad      = 1'b1;
                        good_nx  = '0;
                        state_nx = TRACK;
                    end
                end else if (len == TIMEOUT_LEN) begin
                    bad      = 1'b1;
                    good_nx  = '0;
                    state_nx = SEARCH;
                end
            end
            default: begin
                state_nx = SEARCH;
                good_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rise       <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
            period     <= '0;
            edge_count <= '0;
        end else begin
            rise   <= edge_det;
            locked <= (state_nx == LOCKED);
            err    <= bad | (err & ~err_clr);
            if (eval) period <= len;
            if (edge_det) edge_count <= edge_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hack_clk_monitor.sv
// tb_hack_clk_monitor: directed and randomized checks of hack_clk_monitor against an
// edge-level reference model, for a 2-stage synchronizer and a direct-sampling instance.
module tb_hack_clk_monitor;
    localparam int EXP_PERIOD = 3;
    localparam int EXP_HIGH   = 1;
    localparam int LOCK_COUNT = 4;
    localparam int MAXC       = 8192;

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic hack_clk = 1'b0;
    logic err_clr  = 1'b0;

    logic        rise_a, locked_a, err_a;
    logic [7:0]  period_a;
    logic [15:0] ec_a;
    logic        rise_b, locked_b, err_b;
    logic [7:0]  period_b;
    logic [3:0]  ec_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hack_clk_monitor #(
        .SYNC_STAGES(2), .EXP_PERIOD(EXP_PERIOD), .EXP_HIGH(EXP_HIGH),
        .LOCK_COUNT(LOCK_COUNT), .CNT_W(16)
    ) dut_a (
        .clk(clk), .reset(reset), .hack_clk(hack_clk), .err_clr(err_clr),
        .rise(rise_a), .locked(locked_a), .err(err_a), .period(period_a), .edge_count(ec_a)
    );

    hack_clk_monitor #(
        .SYNC_STAGES(0), .EXP_PERIOD(EXP_PERIOD), .EXP_HIGH(EXP_HIGH),
        .LOCK_COUNT(LOCK_COUNT), .CNT_W(4)
    ) dut_b (
        .clk(clk), .reset(reset), .hack_clk(hack_clk), .err_clr(err_clr),
        .rise(rise_b), .locked(locked_b), .err(err_b), .period(period_b), .edge_count(ec_b)
    );

    // Reference model: sample history plus per-instance edge bookkeeping
    logic hist [0:MAXC-1];
    int   n  = 0;
    int   rr = -1;
    int   m_sync [2] = '{2, 0};
    int   m_wrap [2] = '{65536, 16};
    logic m_track [2];
    logic m_rise [2];
    logic m_err [2];
    int   m_run [2];
    int   m_last [2];
    int   m_period [2];
    int   m_ec [2];
    logic hq [$];
    int   nb = 0;

    function automatic logic s_at(input int k);
        if (k < 0 || k <= rr) return 1'b0;
        return hist[k];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic clr);
        for (int i = 0; i < 2; i++) begin
            logic e;
            logic eset;
            int   len;
            int   hi;
            int   sd;
            if (r) begin
                rr          = n;
                m_track[i]  = 1'b0;
                m_rise[i]   = 1'b0;
                m_err[i]    = 1'b0;
                m_run[i]    = 0;
                m_last[i]   = 0;
                m_period[i] = 0;
                m_ec[i]     = 0;
            end else begin
                sd   = m_sync[i];
                e    = s_at(n - sd) && !s_at(n - sd - 1);
                eset = 1'b0;
                if (e) begin
                    m_ec[i] = (m_ec[i] + 1) % m_wrap[i];
                    if (m_track[i]) begin
                        len = n - m_last[i];
                        hi  = 0;
                        for (int k = m_last[i]; k < n; k++) if (s_at(k - sd)) hi++;
                        m_period[i] = (len > 255) ? 255 : len;
                        if (len == EXP_PERIOD && hi == EXP_HIGH) m_run[i]++;
                        else begin
                            m_run[i] = 0;
                            eset     = 1'b1;
                        end
                    end
                    m_track[i] = 1'b1;
                    m_last[i]  = n;
                end else if (m_track[i] && (n - m_last[i]) == 2 * EXP_PERIOD) begin
                    m_track[i] = 1'b0;
                    m_run[i]   = 0;
                    eset       = 1'b1;
                end
                m_rise[i] = e;
                m_err[i]  = eset | (m_err[i] & !clr);
            end
        end
    endtask

    task automatic compare_all();
        chk("a.rise",   rise_a,   m_rise[0]);
        chk("a.locked", locked_a, (m_track[0] && m_run[0] >= LOCK_COUNT));
        chk("a.err",    err_a,    m_err[0]);
        chk("a.period", period_a, m_period[0]);
        chk("a.count",  ec_a,     m_ec[0]);
        chk("b.rise",   rise_b,   m_rise[1]);
        chk("b.locked", locked_b, (m_track[1] && m_run[1] >= LOCK_COUNT));
        chk("b.err",    err_b,    m_err[1]);
        chk("b.period", period_b, m_period[1]);
        chk("b.count",  ec_b,     m_ec[1]);
    endtask

    task automatic cyc(input logic r, input logic clr);
        logic h;
        if (hq.size() == 0) begin
            hq.push_back(1'b0);
            hq.push_back(1'b0);
            hq.push_back(1'b1);
        end
        h = hq.pop_front();
        @(negedge clk);
        reset    = r;
        err_clr  = clr;
        hack_clk = h;
        hist[n]  = h;
        @(posedge clk);
        model_step(r, clr);
        #1;
        compare_all();
        if (r) nb = 0;
        else if (rise_b) begin
            nb++;
            if (nb == 15) chk("b.wrap15", ec_b, 15);
            if (nb == 16) chk("b.wrap0", ec_b, 0);
        end
        n++;
    endtask

    task automatic wait_rise();
        int k;
        k = 0;
        do begin
            cyc(1'b0, 1'b0);
            k++;
        end while (!rise_a && k < 20);
        checks++;
        assert (rise_a === 1'b1) else begin
            errors++;
            $error("FAIL wait_rise got no rise in %0d cycles expected a rise", k);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".rise_a"}, rise_a, 0);
        chk({tag, ".locked_a"}, locked_a, 0);
        chk({tag, ".err_a"}, err_a, 0);
        chk({tag, ".period_a"}, period_a, 0);
        chk({tag, ".count_a"}, ec_a, 0);
        chk({tag, ".rise_b"}, rise_b, 0);
        chk({tag, ".err_b"}, err_b, 0);
        chk({tag, ".count_b"}, ec_b, 0);
    endtask

    initial begin
        int   lat_a;
        int   lat_b;
        int   k;
        int   len;
        int   hi;
        int   sel;
        int   reps;
        logic v;
        logic r;

        // reset state
        repeat (3) cyc(1'b1, 1'b0);
        chk_zero("reset");

        // latency and first lock
        hq.delete();
        hq.push_back(1'b1);
        lat_a = 0;
        lat_b = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b0, 1'b0);
            if (rise_b && lat_b == 0) lat_b = i;
            if (rise_a && lat_a == 0) lat_a = i;
            if (lat_a != 0 && lat_b != 0) break;
        end
        chk("lat_sync2", lat_a, 3);
        chk("lat_sync0", lat_b, 1);
        repeat (3) wait_rise();
        chk("lock4.locked", locked_a, 0);
        wait_rise();
        chk("lock5.locked", locked_a, 1);
        chk("lock5.count", ec_a, 5);
        chk("lock5.period", period_a, 3);
        chk("lock5.err", err_a, 0);
        k = 0;
        do begin
            cyc(1'b0, 1'b0);
            k++;
        end while (!rise_a && k < 20);
        chk("rise_gap", k, 3);

        // stretched period 0 0 0 1
        wait_rise();
        hq.delete();
        hq.push_back(1'b0);
        hq.push_back(1'b1);
        wait_rise();
        chk("stretch.period", period_a, 4);
        chk("stretch.locked", locked_a, 0);
        chk("stretch.err", err_a, 1);
        repeat (3) wait_rise();
        chk("stretch.relock3", locked_a, 0);
        wait_rise();
        chk("stretch.relock4", locked_a, 1);
        chk("stretch.err_sticky", err_a, 1);
        cyc(1'b0, 1'b1);
        chk("stretch.err_clr", err_a, 0);

        // high time 2 in a 3-cycle period, with err_clr on the same cycle
        wait_rise();
        hq.delete();
        hq.push_back(1'b1);
        hq.push_back(1'b1);
        hq.push_back(1'b0);
        hq.push_back(1'b1);
        wait_rise();
        chk("hi2.prev_locked", locked_a, 1);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        chk("hi2.rise", rise_a, 1);
        chk("hi2.locked", locked_a, 0);
        chk("hi2.err_set_wins", err_a, 1);
        chk("hi2.period", period_a, 3);
        repeat (3) wait_rise();
        chk("hi2.relock3", locked_a, 0);
        wait_rise();
        chk("hi2.relock4", locked_a, 1);
        cyc(1'b0, 1'b1);

        // edge coinciding with the timeout length
        wait_rise();
        hq.delete();
        hq.push_back(1'b0);
        hq.push_back(1'b0);
        hq.push_back(1'b0);
        hq.push_back(1'b1);
        wait_rise();
        chk("coll.period", period_a, 6);
        chk("coll.locked", locked_a, 0);
        chk("coll.err", err_a, 1);
        repeat (3) wait_rise();
        chk("coll.relock3", locked_a, 0);
        wait_rise();
        chk("coll.relock4", locked_a, 1);

        // stuck low timeout and re-arm
        wait_rise();
        hq.delete();
        repeat (12) hq.push_back(1'b0);
        k = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc(1'b0, 1'b0);
            if (!locked_a) begin
                k = i;
                break;
            end
        end
        chk("stuck.cycles", k, 6);
        chk("stuck.err", err_a, 1);
        chk("stuck.period", period_a, 3);
        hq.delete();
        hq.push_back(1'b1);
        wait_rise();
        chk("rearm.locked", locked_a, 0);
        chk("rearm.period", period_a, 3);
        repeat (3) wait_rise();
        chk("rearm.relock3", locked_a, 0);
        wait_rise();
        chk("rearm.relock4", locked_a, 1);

        // reset mid-lock with hack_clk high
        wait_rise();
        hq.delete();
        hq.push_back(1'b1);
        hq.push_back(1'b1);
        cyc(1'b1, 1'b0);
        chk_zero("midrst");
        repeat (4) wait_rise();
        chk("midrst.lock4", locked_a, 0);
        chk("midrst.err4", err_a, 0);
        wait_rise();
        chk("midrst.lock5", locked_a, 1);
        chk("midrst.err5", err_a, 0);
        chk("midrst.count5", ec_a, 5);

        // randomized periods, stuck runs, resets and clears
        for (int i = 0; i < 800; i++) begin
            r = 1'b0;
            if (hq.size() == 0) begin
                sel = int'($urandom_range(0, 99));
                if (sel < 55) begin
                    hq.push_back(1'b0);
                    hq.push_back(1'b0);
                    hq.push_back(1'b1);
                end else if (sel < 80) begin
                    len = int'($urandom_range(2, 8));
                    hi  = int'($urandom_range(1, len - 1));
                    for (int j = 0; j < len - hi; j++) hq.push_back(1'b0);
                    for (int j = 0; j < hi; j++) hq.push_back(1'b1);
                end else if (sel < 93) begin
                    v    = 1'($urandom_range(0, 1));
                    reps = int'($urandom_range(3, 10));
                    for (int j = 0; j < reps; j++) hq.push_back(v);
                end else begin
                    r = 1'b1;
                end
            end
            cyc(r, ($urandom_range(0, 9) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
